// File: rtl/axi_slave_wr_ctrl.sv
// axi_slave_wr_ctrl: AXI4 slave write-path controller.
// Accepts one AW burst at a time, turns every W beat into a registered
// single-cycle write on a local SRAM-style port, then returns a B response.
// Optional feature macro: AXI_SLV_WRAP_EN (WRAP burst support). When it is
// undefined, WRAP bursts are answered with SLVERR and their writes dropped.
//
// Handshake rule: a transfer on any channel happens on the rising clock
// edge where both VALID and READY are high. READY and VALID outputs come
// straight from registers, so they are stable for the whole cycle.
module axi_slave_wr_ctrl #(
  parameter int ID_WIDTH       = 4,
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 64,
  parameter int MEM_ADDR_WIDTH = 10
) (
  input  logic                      AXI_ACLK,
  input  logic                      AXI_ARESET,
  input  logic                      AXI_AWVALID,
  output logic                      AXI_AWREADY,
  input  logic [ID_WIDTH-1:0]       AXI_AWID,
  input  logic [ADDR_WIDTH-1:0]     AXI_AWADDR,
  input  logic [7:0]                AXI_AWLEN,
  input  logic [2:0]                AXI_AWSIZE,
  input  logic [1:0]                AXI_AWBURST,
  input  logic                      AXI_WVALID,
  output logic                      AXI_WREADY,
  input  logic [DATA_WIDTH-1:0]     AXI_WDATA,
  input  logic [DATA_WIDTH/8-1:0]   AXI_WSTRB,
  input  logic                      AXI_WLAST,
  output logic                      AXI_BVALID,
  input  logic                      AXI_BREADY,
  output logic [ID_WIDTH-1:0]       AXI_BID,
  output logic [1:0]                AXI_BRESP,
  output logic                      mem_we,
  output logic [MEM_ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0]     mem_wdata,
  output logic [DATA_WIDTH/8-1:0]   mem_wstrb
);

  localparam int ADDR_LSB = $clog2(DATA_WIDTH / 8);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_DATA = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  logic [1:0]            state;
  logic                  awready_q;
  logic [ID_WIDTH-1:0]   id_q;
  logic [ADDR_WIDTH-1:0] cur_addr;
  logic [7:0]            len_q;
  logic [7:0]            beat_cnt;
  logic [2:0]            size_q;
  logic [1:0]            burst_q;
  logic                  err_q;   // reported in BRESP
  logic                  sup_q;   // burst rejected at AW time: drop all writes

  logic                  aw_hs;
  logic                  w_hs;
  logic                  last_beat;
  logic                  cap_err;
  logic [ADDR_WIDTH-1:0] size_bytes;
  logic [ADDR_WIDTH-1:0] next_addr;

  assign aw_hs     = AXI_AWVALID && awready_q;
  assign w_hs      = AXI_WVALID && (state == ST_DATA);
  assign last_beat = (beat_cnt == len_q);

  assign AXI_AWREADY = awready_q;
  assign AXI_WREADY  = (state == ST_DATA);
  assign AXI_BVALID  = (state == ST_RESP);
  assign AXI_BID     = id_q;
  assign AXI_BRESP   = {err_q, 1'b0};

  // Burst-level errors detectable from the AW channel alone.
  always_comb begin
    cap_err = 1'b0;
    if (int'(AXI_AWSIZE) > ADDR_LSB) cap_err = 1'b1;
    if (AXI_AWBURST == 2'b11) cap_err = 1'b1;
`ifdef AXI_SLV_WRAP_EN
    if ((AXI_AWBURST == 2'b10) &&
        !((AXI_AWLEN == 8'd1) || (AXI_AWLEN == 8'd3) ||
          (AXI_AWLEN == 8'd7) || (AXI_AWLEN == 8'd15)))
      cap_err = 1'b1;
`else
    if (AXI_AWBURST == 2'b10) cap_err = 1'b1;
`endif
  end

  // Address of the following beat for the latched burst type.
  always_comb begin
    size_bytes = ADDR_WIDTH'(1) << size_q;
    next_addr  = cur_addr;
    case (burst_q)
      2'b01:   next_addr = (cur_addr & ~(size_bytes - ADDR_WIDTH'(1))) + size_bytes;
`ifdef AXI_SLV_WRAP_EN
      2'b10:   next_addr = (cur_addr & ~(((ADDR_WIDTH'(len_q) + ADDR_WIDTH'(1)) << size_q) - ADDR_WIDTH'(1))) |
                           ((cur_addr + size_bytes) &
                            (((ADDR_WIDTH'(len_q) + ADDR_WIDTH'(1)) << size_q) - ADDR_WIDTH'(1)));
`endif
      default: next_addr = cur_addr;
    endcase
  end

  // Control FSM, burst bookkeeping and the registered memory write port.
  always_ff @(posedge AXI_ACLK) begin
    if (AXI_ARESET) begin
      state     <= ST_IDLE;
      awready_q <= 1'b0;
      id_q      <= '0;
      cur_addr  <= '0;
      len_q     <= '0;
      beat_cnt  <= '0;
      size_q    <= '0;
      burst_q   <= '0;
      err_q     <= 1'b0;
      sup_q     <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_wstrb <= '0;
    end else begin
      mem_we <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (aw_hs) begin
            id_q      <= AXI_AWID;
            cur_addr  <= AXI_AWADDR;
            len_q     <= AXI_AWLEN;
            size_q    <= AXI_AWSIZE;
            burst_q   <= AXI_AWBURST;
            beat_cnt  <= 8'd0;
            err_q     <= cap_err;
            sup_q     <= cap_err;
            awready_q <= 1'b0;
            state     <= ST_DATA;
          end else begin
            awready_q <= 1'b1;
          end
        end
        ST_DATA: begin
          if (w_hs) begin
            mem_we    <= !sup_q;
            mem_addr  <= cur_addr[ADDR_LSB +: MEM_ADDR_WIDTH];
            mem_wdata <= AXI_WDATA;
            mem_wstrb <= AXI_WSTRB;
            if (AXI_WLAST != last_beat) err_q <= 1'b1;
            cur_addr  <= next_addr;
            beat_cnt  <= beat_cnt + 8'd1;
            if (last_beat) state <= ST_RESP;
          end
        end
        ST_RESP: begin
          if (AXI_BREADY) begin
            state     <= ST_IDLE;
            awready_q <= 1'b1;
          end
        end
        default: begin
          state     <= ST_IDLE;
          awready_q <= 1'b0;
        end
      endcase
    end
  end

endmodule
